// File: rtl/seg_pkg.sv
// Shared constants, scan-state type and anode decode for the multiplexed
// 8-digit segment scan driver.
package seg_pkg;
  localparam int NUM_DIGITS = 8;
  localparam int SEG_W      = 8;
  localparam int IDX_W      = 3;
  localparam int DATA_W     = NUM_DIGITS * SEG_W;

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    BLANK,
    DRIVE
  } scan_state_e;

  // Active-low one-hot anode select for digit idx.
  function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [IDX_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction
endpackage

// File: rtl/seg_slot_timer.sv
// Slot timer: per-digit cycle counter, digit index, blank/drive phase decode
// and frame start/done strobes.
module seg_slot_timer
  import seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [IDX_W-1:0] idx_o,
  output scan_state_e      state_o,
  output logic             frame_start_o,
  output logic             frame_done_o
);
  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_param_check
    $error("seg_slot_timer: require 1 <= BLANK_CYCLES < DIGIT_CYCLES");
  end

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!en_i) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Counter and index sit at 0 while disabled, so the first enabled cycle is
  // always a frame start and frame_done cannot fire while idle.
  assign idx_o         = idx_q;
  assign state_o       = (cnt_q < CNT_BLANK) ? BLANK : DRIVE;
  assign frame_start_o = en_i && (cnt_q == '0) && (idx_q == '0);
  assign frame_done_o  = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
endmodule

// File: rtl/seg_scan_drv.sv
// Multiplexed 8-digit segment driver: one-word pending buffer with ready/valid
// handshake, frame-aligned display update and registered segment/anode drive.
module seg_scan_drv
  import seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] seg_data,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [SEG_W-1:0]  seg,
  output logic [SEG_W-1:0]  an,
  output logic              frame_done
);
  logic [IDX_W-1:0] idx;
  scan_state_e      state;
  logic             frame_start;

  seg_slot_timer #(
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (en),
    .idx_o         (idx),
    .state_o       (state),
    .frame_start_o (frame_start),
    .frame_done_o  (frame_done)
  );

  logic [NUM_DIGITS-1:0][SEG_W-1:0] pend_q;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] disp_q, disp_d;
  logic                             pend_full_q, pend_full_d;
  logic                             disp_vld_q, disp_vld_d;
  logic [SEG_W-1:0]                 seg_q, seg_d;
  logic [SEG_W-1:0]                 an_q, an_d;
  logic                             accept;
  logic                             load;

  assign data_ready = !pend_full_q;
  assign accept     = data_valid && !pend_full_q;
  // Uses pend_full_q from before the boundary, so a word accepted in the
  // boundary cycle itself waits for the next frame.
  assign load       = frame_start && pend_full_q;

  always_comb begin
    pend_full_d = pend_full_q;
    disp_d      = disp_q;
    disp_vld_d  = disp_vld_q;
    seg_d       = SEG_BLANK;
    an_d        = SEG_BLANK;
    if (load) begin
      pend_full_d = 1'b0;
      disp_d      = pend_q;
      disp_vld_d  = 1'b1;
    end else if (accept) begin
      pend_full_d = 1'b1;
    end
    // Anodes stay off until a word has actually been displayed.
    if (en && state == DRIVE && disp_vld_q) begin
      seg_d = disp_q[idx];
      an_d  = anode_sel(idx);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pend_q <= seg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full_q <= 1'b0;
      disp_vld_q  <= 1'b0;
      disp_q      <= {NUM_DIGITS{SEG_BLANK}};
      seg_q       <= SEG_BLANK;
      an_q        <= SEG_BLANK;
    end else begin
      pend_full_q <= pend_full_d;
      disp_vld_q  <= disp_vld_d;
      disp_q      <= disp_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
endmodule

// File: tb/tb_seg_scan_drv.sv
// Directed bench for seg_scan_drv with DIGIT_CYCLES=8, BLANK_CYCLES=2.
module tb_seg_scan_drv;
  localparam int DC = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [63:0] seg_data;
  logic        data_valid;
  logic        data_ready;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  seg_scan_drv #(
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .seg_data   (seg_data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [7:0] seg;
    logic [7:0] an;
    logic       fd;
    logic       rdy;
  } vec_t;

  vec_t tbl [17];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at sample %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Compares {seg, an, frame_done} as one word.
  task automatic chk_out(input string name, input logic [7:0] es, input logic [7:0] ea,
                         input logic efd);
    chk(name, 32'({seg, an, frame_done}), 32'({es, ea, efd}));
  endtask

  initial begin
    int b;
    logic [63:0] wa, wb, wc, wd, we;
    wa = 64'hA7A6A5A4A3A2A1A0;
    wb = 64'hB7B6B5B4B3B2B1B0;
    wc = 64'h5756555453525150;
    wd = 64'h6766656463626160;
    we = 64'hE7E6E5E4E3E2E1E0;

    tbl[0]  = '{0,  8'hFF, 8'hFF, 1'b0, 1'b0};
    tbl[1]  = '{1,  8'hFF, 8'hFF, 1'b0, 1'b1};
    tbl[2]  = '{2,  8'hFF, 8'hFF, 1'b0, 1'b1};
    tbl[3]  = '{3,  8'hC0, 8'hFE, 1'b0, 1'b1};
    tbl[4]  = '{8,  8'hC0, 8'hFE, 1'b0, 1'b1};
    tbl[5]  = '{9,  8'hFF, 8'hFF, 1'b0, 1'b1};
    tbl[6]  = '{10, 8'hFF, 8'hFF, 1'b0, 1'b1};
    tbl[7]  = '{11, 8'hC1, 8'hFD, 1'b0, 1'b1};
    tbl[8]  = '{22, 8'hC2, 8'hFB, 1'b0, 1'b1};
    tbl[9]  = '{28, 8'hC3, 8'hF7, 1'b0, 1'b1};
    tbl[10] = '{35, 8'hC4, 8'hEF, 1'b0, 1'b1};
    tbl[11] = '{48, 8'hC5, 8'hDF, 1'b0, 1'b1};
    tbl[12] = '{56, 8'hC6, 8'hBF, 1'b0, 1'b1};
    tbl[13] = '{60, 8'hC7, 8'h7F, 1'b0, 1'b1};
    tbl[14] = '{63, 8'hC7, 8'h7F, 1'b1, 1'b1};
    tbl[15] = '{64, 8'hC7, 8'h7F, 1'b0, 1'b1};
    tbl[16] = '{67, 8'hC0, 8'hFE, 1'b0, 1'b1};

    // Reset with en high and no data.
    rst_n      = 1'b0;
    en         = 1'b1;
    data_valid = 1'b0;
    seg_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset_out", 8'hFF, 8'hFF, 1'b0);
    chk("reset_ready", 32'(data_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;

    // Three idle frames: outputs blank, frame_done on sample 63 mod 64.
    for (int j = 0; j < 192; j++) begin
      chk_out("idle_frame", 8'hFF, 8'hFF, (j % 64) == 63);
      tick();
    end

    // Word C7..C0 accepted mid-frame, displayed from the next boundary (256).
    tick_to(195);
    chk("load_ready_before", 32'(data_ready), 32'd1);
    data_valid = 1'b1;
    seg_data   = 64'hC7C6C5C4C3C2C1C0;
    tick();
    data_valid = 1'b0;
    chk("load_ready_after", 32'(data_ready), 32'd0);
    b = 256;
    for (int i = 0; i < 17; i++) begin
      tick_to(b + tbl[i].at);
      chk_out("table_out", tbl[i].seg, tbl[i].an, tbl[i].fd);
      chk("table_ready", 32'(data_ready), 32'(tbl[i].rdy));
    end

    // Back-to-back A then B: B is refused and never displayed.
    tick_to(330);
    data_valid = 1'b1;
    seg_data   = wa;
    chk("ab_ready_a", 32'(data_ready), 32'd1);
    tick();
    seg_data = wb;
    chk("ab_ready_b", 32'(data_ready), 32'd0);
    tick_to(384);
    chk("ab_ready_boundary", 32'(data_ready), 32'd0);
    data_valid = 1'b0;
    tick();
    chk("ab_ready_cleared", 32'(data_ready), 32'd1);
    tick_to(387);
    chk_out("ab_digit0", 8'hA0, 8'hFE, 1'b0);
    tick_to(403);
    chk_out("ab_digit2", 8'hA2, 8'hFB, 1'b0);
    tick_to(447);
    chk_out("ab_digit7", 8'hA7, 8'h7F, 1'b1);
    tick_to(451);
    chk_out("ab_no_b", 8'hA0, 8'hFE, 1'b0);

    // C accepted on the boundary cycle itself: shown one frame later.
    tick_to(512);
    chk("c_ready_boundary", 32'(data_ready), 32'd1);
    data_valid = 1'b1;
    seg_data   = wc;
    tick();
    data_valid = 1'b0;
    chk("c_accepted", 32'(data_ready), 32'd0);
    tick_to(515);
    chk_out("c_not_yet_d0", 8'hA0, 8'hFE, 1'b0);
    tick_to(547);
    chk_out("c_not_yet_d4", 8'hA4, 8'hEF, 1'b0);
    tick_to(576);
    chk("c_ready_held", 32'(data_ready), 32'd0);
    tick();
    chk("c_ready_loaded", 32'(data_ready), 32'd1);
    tick_to(579);
    chk_out("c_shown_d0", 8'h50, 8'hFE, 1'b0);
    tick_to(639);
    chk_out("c_shown_d7", 8'h57, 8'h7F, 1'b1);

    // en dropped during digit 4 DRIVE, word D offered while disabled.
    tick_to(676);
    chk_out("en_before_drop", 8'h54, 8'hEF, 1'b0);
    en = 1'b0;
    repeat (20) begin
      tick();
      chk_out("en_low_out", 8'hFF, 8'hFF, 1'b0);
      if (cyc == 680) begin
        chk("en_low_ready", 32'(data_ready), 32'd1);
        data_valid = 1'b1;
        seg_data   = wd;
      end else if (cyc == 681) begin
        chk("en_low_accept", 32'(data_ready), 32'd0);
        data_valid = 1'b0;
      end
    end
    en = 1'b1;
    b  = cyc;
    tick_to(b + 1);
    chk_out("en_rise_blank0", 8'hFF, 8'hFF, 1'b0);
    chk("en_rise_loaded", 32'(data_ready), 32'd1);
    tick_to(b + 2);
    chk_out("en_rise_blank1", 8'hFF, 8'hFF, 1'b0);
    tick_to(b + 3);
    chk_out("en_rise_d0", 8'h60, 8'hFE, 1'b0);
    tick_to(b + 8);
    chk_out("en_rise_d0_end", 8'h60, 8'hFE, 1'b0);
    tick_to(b + 9);
    chk_out("en_rise_d1_blank", 8'hFF, 8'hFF, 1'b0);
    tick_to(b + 11);
    chk_out("en_rise_d1", 8'h61, 8'hFD, 1'b0);
    tick_to(b + 63);
    chk_out("en_rise_d7", 8'h67, 8'h7F, 1'b1);

    // Reset pulsed mid-DRIVE with word E pending.
    b = cyc + 1;
    tick_to(b + 5);
    data_valid = 1'b1;
    seg_data   = we;
    tick();
    data_valid = 1'b0;
    chk("rst_pending_full", 32'(data_ready), 32'd0);
    tick_to(b + 21);
    chk_out("rst_pre_drive", 8'h62, 8'hFB, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_async_out", 8'hFF, 8'hFF, 1'b0);
    chk("rst_async_ready", 32'(data_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    for (int j = 0; j < 72; j++) begin
      chk_out("post_rst_blank", 8'hFF, 8'hFF, j == 63);
      if (j == 1 || j == 65) chk("post_rst_ready", 32'(data_ready), 32'd1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg_scan_drv.md
SEG_SCAN_DRV -- requirements
Module: seg_scan_drv

Interface
REQ-001 Parameter DIGIT_CYCLES, default 100000, is the clock cycles per digit slot (1 ms at 100 MHz).
REQ-002 Parameter BLANK_CYCLES, default 1000, is the cycles at the start of each slot during which all digits are off (anti-ghosting).
REQ-003 Port clk  input  1  is the single clock; all logic is on its rising edge.
REQ-004 Port rst_n  input  1  is the reset: asynchronous, active-low.
REQ-005 Port en  input  1  enables scanning; when low, the display is blanked.
REQ-006 Port seg_data  input  64  carries eight 8-bit active-low segment patterns; digit k uses bits [8k+7:8k], bit 7 of each byte is dp.
REQ-007 Port data_valid  input  1  means seg_data is offered this cycle.
REQ-008 Port data_ready  output  1  means the block accepts seg_data this cycle.
REQ-009 Port seg  output  8  is the active-low segment/dp drive.
REQ-010 Port an  output  8  is the active-low digit anode select (one-hot-low).
REQ-011 Port frame_done  output  1  is a one-cycle pulse at the end of each 8-digit frame.

Function
REQ-012 Transfer occurs on any cycle where data_valid and data_ready are both high; the word is written to the pending register and pending_full is set.
REQ-013 data_ready SHALL equal !pending_full.
REQ-014 With data_valid high and data_ready low, seg_data is ignored and has no effect.
REQ-015 The display register is loaded from pending only at a frame boundary (the first cycle of digit-0 slot), and pending_full is cleared in that cycle.
REQ-016 For the boundary transfer, the pending value as registered before that cycle is used; a word accepted in the boundary cycle is held for the next frame.
REQ-017 Frames are never torn: the display register is constant for all 8 slots of a frame.
REQ-018 The slot counter runs 0..DIGIT_CYCLES-1; the digit index increments 0..7 at counter wrap and wraps 7->0.
REQ-019 State BLANK (counter < BLANK_CYCLES): seg=8'hFF, an=8'hFF.
REQ-020 State DRIVE (counter >= BLANK_CYCLES): seg=display[8k+7:8k], an=~(8'b1<<k), where k is the digit index.
REQ-021 seg and an are registered and follow the state, counter and index with exactly one cycle of latency.
REQ-022 frame_done pulses high for one cycle while counter=DIGIT_CYCLES-1 and index=7, independent of en.
REQ-023 When en is low, the counter and index are held at 0, seg=an=8'hFF, and frame_done=0; the pending handshake still operates.
REQ-024 When en rises, scanning starts at digit 0, counter 0, and that cycle is a frame boundary.
REQ-025 Parameter legality is 1 <= BLANK_CYCLES < DIGIT_CYCLES; elaboration SHALL fail otherwise.

Reset
REQ-026 The following SHALL be the reset values:
- seg = 8'hFF
- an = 8'hFF
- frame_done = 0
- data_ready = 1
- pending_full = 0
- display register = all 8'hFF (blank)
- counter = 0
- index = 0
REQ-027 Reset asserted mid-frame SHALL immediately blank the outputs and discard pending data.
REQ-028 After rst_n deasserts with en high, the first cycle is a frame boundary.

Structure
REQ-029 Shared package seg_pkg SHALL hold NUM_DIGITS=8, SEG_BLANK=8'hFF, and the scan-state enum {BLANK, DRIVE}.
REQ-030 One sub-module, seg_slot_timer, SHALL hold the slot counter, digit index and frame_done generation; seg_scan_drv holds the handshake, registers and output muxing.

Verification (DIGIT_CYCLES=8, BLANK_CYCLES=2)
REQ-031 Reset then en=1, no data -> seg=an=8'hFF throughout; frame_done first high at cycle 63 after release, period 64.
REQ-032 Load 64'h... with byte k = 8'hC0+k, accepted before a boundary -> next frame, digit k slot: 2 cycles seg=an=FF, then 6 cycles seg=C0+k, an=~(1<<k).
REQ-033 Two back-to-back valid words A, B with no boundary between them -> A accepted, data_ready low, B refused; A is displayed and B never appears.
REQ-034 Word C accepted exactly on a boundary cycle while pending is empty -> C is not shown in that frame; it is shown from the following frame.
REQ-035 en dropped during digit 4 DRIVE -> next-cycle outputs are FF and frame_done stays 0; en raised -> display restarts at digit 0 with the blank phase.
REQ-036 rst_n pulsed low mid-DRIVE with pending full -> outputs FF asynchronously, data_ready=1 and display blank after release.
